// File: rtl/frog_pkg.sv
// frog_pkg: shared state/direction types and datapath widths for the frog movement block
package frog_pkg;
  localparam int COORD_W = 10;
  localparam int SCORE_W = 6;
  localparam int LIVES_W = 3;
  typedef enum logic [1:0] {IDLE, HOP, RESPAWN, DEAD} state_t;
  typedef enum logic [1:0] {UP, DN, LT, RT} dir_t;
endpackage

// File: rtl/frog_move_req.sv
// frog_move_req: turns raw direction buttons into single-cycle move requests
// Ports: clk, rst (async, active-high), en (holds all state when low),
//   btn {rt,lt,dn,up}, valid (move request this cycle), dir (requested direction).
// Build option FROG_AUTO_REPEAT_EN: a single button held steadily re-requests every REPEAT_CYCLES.
module frog_move_req
  import frog_pkg::*;
#(
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] btn,
  output logic       valid,
  output dir_t       dir
);
`ifdef FROG_AUTO_REPEAT_EN
  localparam bit AUTO_REPEAT = 1'b1;
`else
  localparam bit AUTO_REPEAT = 1'b0;
`endif
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [3:0] prev;
  logic [RW-1:0] rpt_cnt;
  logic one_hot, same, rpt_fire;
  assign one_hot = $onehot(btn);
  // same single button as last cycle: the only case where the repeat counter advances
  assign same = one_hot && btn == prev;
  assign rpt_fire = AUTO_REPEAT && same && rpt_cnt == RW'(REPEAT_CYCLES - 1);
  assign valid = en && one_hot && (prev == '0 || rpt_fire);
  always_comb dir = btn[1] ? DN : btn[2] ? LT : btn[3] ? RT : UP;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= '0;
      rpt_cnt <= '0;
    end else if (en) begin
      prev <= btn;
      rpt_cnt <= (!AUTO_REPEAT || !same || rpt_fire) ? '0 : rpt_cnt + 1'b1;
    end
endmodule

// File: rtl/frog_motion_fsm.sv
// frog_motion_fsm: grid-based frog controller with animated hops, lives, respawn blink and game over
// Ports: clk, rst (async, active-high), game_active (low freezes everything),
//   frog_up/dn/lt/rt buttons, has_collided, restart;
//   frog_x/frog_y position, draw_frog, level_up pulse, score, lives, game_over, busy.
// Build option FROG_AUTO_REPEAT_EN: held-button auto-repeat (see frog_move_req).
module frog_motion_fsm
  import frog_pkg::*;
#(
  parameter int c_SCORE_INI       = 1,
  parameter int c_LIVES_INI       = 3,
  parameter int c_X_BASE_POSITION = 320,
  parameter int c_Y_BASE_POSITION = 384,
  parameter int TILE_SIZE         = 32,
  parameter int HOP_PX            = 4,
  parameter int HOP_DIV           = 390625,
  parameter int RESPAWN_CYCLES    = 50000000,
  parameter int BLINK_DIV         = 3125000,
  parameter int REPEAT_CYCLES     = 12500000,
  parameter int H_VISIBLE_AREA    = 640,
  parameter int V_VISIBLE_AREA    = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_active,
  input  logic               frog_up,
  input  logic               frog_dn,
  input  logic               frog_lt,
  input  logic               frog_rt,
  input  logic               has_collided,
  input  logic               restart,
  output logic [COORD_W-1:0] frog_x,
  output logic [COORD_W-1:0] frog_y,
  output logic               draw_frog,
  output logic               level_up,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               busy
);
  localparam int STEPS = TILE_SIZE / HOP_PX;
  localparam int SW = $clog2(STEPS + 1);
  localparam int DW = $clog2(HOP_DIV + 1);
  localparam int RW = $clog2(RESPAWN_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [COORD_W-1:0] XB = COORD_W'(c_X_BASE_POSITION);
  localparam logic [COORD_W-1:0] YB = COORD_W'(c_Y_BASE_POSITION);
  localparam logic [COORD_W-1:0] HP = COORD_W'(HOP_PX);
  localparam logic [SCORE_W-1:0] SCORE_INI = SCORE_W'(c_SCORE_INI);
  localparam logic [LIVES_W-1:0] LIVES_INI = LIVES_W'(c_LIVES_INI);
  state_t state;
  dir_t dir_q, req_dir;
  logic req_valid, tgt_ok, tick, last, goal, lvl_q;
  logic [SW-1:0] step_cnt;
  logic [DW-1:0] div_cnt;
  logic [RW-1:0] resp_cnt;
  logic [BW-1:0] blink_cnt;
  logic [COORD_W-1:0] nx, ny;
  frog_move_req #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_req (
    .clk   (clk),
    .rst   (rst),
    .en    (game_active),
    .btn   ({frog_rt, frog_lt, frog_dn, frog_up}),
    .valid (req_valid),
    .dir   (req_dir)
  );
  // Up is never bounds-checked: from the top row it is the goal hop
  always_comb begin
    tgt_ok = req_dir == UP || (req_dir == DN ? int'(frog_y) + TILE_SIZE <= V_VISIBLE_AREA - TILE_SIZE :
                               req_dir == LT ? int'(frog_x) >= TILE_SIZE :
                                               int'(frog_x) + TILE_SIZE <= H_VISIBLE_AREA - TILE_SIZE);
    nx = dir_q == LT ? frog_x - HP : dir_q == RT ? frog_x + HP : frog_x;
    ny = dir_q == UP ? frog_y - HP : dir_q == DN ? frog_y + HP : frog_y;
    tick = div_cnt == DW'(HOP_DIV - 1);
    last = tick && step_cnt == SW'(STEPS - 1);
    goal = last && dir_q == UP && ny == '0;
  end
  assign level_up = lvl_q & game_active;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      dir_q <= UP;
      frog_x <= XB;
      frog_y <= YB;
      score <= SCORE_INI;
      lives <= LIVES_INI;
      draw_frog <= 1'b1;
      lvl_q <= 1'b0;
      game_over <= 1'b0;
      busy <= 1'b0;
      step_cnt <= '0;
      div_cnt <= '0;
      resp_cnt <= '0;
      blink_cnt <= '0;
    end else if (game_active) begin
      lvl_q <= 1'b0;
      // collision outranks both a new move and a goal completion in the same cycle
      if ((state == IDLE || state == HOP) && has_collided) begin
        frog_x <= XB;
        frog_y <= YB;
        busy <= 1'b0;
        if (lives == LIVES_W'(1)) begin
          lives <= '0;
          game_over <= 1'b1;
          draw_frog <= 1'b1;
          state <= DEAD;
        end else begin
          lives <= lives - 1'b1;
          resp_cnt <= '0;
          blink_cnt <= '0;
          state <= RESPAWN;
        end
      end else if (state == IDLE) begin
        if (req_valid && tgt_ok) begin
          state <= HOP;
          busy <= 1'b1;
          dir_q <= req_dir;
          div_cnt <= '0;
          step_cnt <= '0;
        end
      end else if (state == HOP) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          step_cnt <= step_cnt + 1'b1;
          frog_x <= nx;
          frog_y <= ny;
          if (last) begin
            state <= IDLE;
            busy <= 1'b0;
          end
          if (goal) begin
            frog_x <= XB;
            frog_y <= YB;
            score <= score == '1 ? score : score + 1'b1;
            lvl_q <= 1'b1;
          end
        end
      end else if (state == RESPAWN) begin
        resp_cnt <= resp_cnt + 1'b1;
        blink_cnt <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + 1'b1;
        draw_frog <= blink_cnt == BW'(BLINK_DIV - 1) ? ~draw_frog : draw_frog;
        if (resp_cnt == RW'(RESPAWN_CYCLES - 1)) begin
          state <= IDLE;
          draw_frog <= 1'b1;
        end
      end else if (restart) begin
        state <= IDLE;
        frog_x <= XB;
        frog_y <= YB;
        score <= SCORE_INI;
        lives <= LIVES_INI;
        draw_frog <= 1'b1;
        game_over <= 1'b0;
        busy <= 1'b0;
      end
    end
endmodule
